msrv32_integer_file_sb: RTL

- Consumer end of the writeback path: takes the value selected by the writeback mux and commits it to the 32-entry integer register file.
- Provides two combinational read ports for decode/operand fetch.
- Holds a per-register busy scoreboard:
  - decode marks a destination busy at issue;
  - the writeback commit clears it;
  - the block raises a stall when a source operand is still pending.
- Sits between the writeback mux select unit and the decode/operand stage.

---
 rtl/msrv32_integer_file_sb_if.sv | 31 +++
 rtl/msrv32_integer_file_sb.sv | 76 +++++++
 2 files changed

// File: rtl/msrv32_integer_file_sb_if.sv
// Writeback, issue and operand-read signals of the integer register file.
// The master modport is the core side (writeback mux + decode); the slave modport is the register file.
interface msrv32_integer_file_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  wr_en_in;
  logic [ADDR_WIDTH-1:0] rd_addr_in;
  logic [DATA_WIDTH-1:0] rd_in;
  logic                  issue_en_in;
  logic [ADDR_WIDTH-1:0] issue_rd_addr_in;
  logic [ADDR_WIDTH-1:0] rs_1_addr_in;
  logic [ADDR_WIDTH-1:0] rs_2_addr_in;
  logic [DATA_WIDTH-1:0] rs_1_out;
  logic [DATA_WIDTH-1:0] rs_2_out;
  logic                  rs_1_busy_out;
  logic                  rs_2_busy_out;
  logic                  stall_out;

  modport master (
    output wr_en_in, rd_addr_in, rd_in, issue_en_in, issue_rd_addr_in,
           rs_1_addr_in, rs_2_addr_in,
    input  rs_1_out, rs_2_out, rs_1_busy_out, rs_2_busy_out, stall_out
  );

  modport slave (
    input  wr_en_in, rd_addr_in, rd_in, issue_en_in, issue_rd_addr_in,
           rs_1_addr_in, rs_2_addr_in,
    output rs_1_out, rs_2_out, rs_1_busy_out, rs_2_busy_out, stall_out
  );
endinterface

// File: rtl/msrv32_integer_file_sb.sv
// Integer register file with per-register busy scoreboard and operand stall.
// Optional same-cycle writeback forwarding: define MSRV32_RF_WB_BYPASS_EN.
module msrv32_integer_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  msrv32_integer_file_sb_if.slave rf
);
  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_reg [NREG];
  logic [NREG-1:0]       busy_reg;
  logic [NREG-1:0]       busy_next;
  logic                  wr_hit;
  logic                  issue_hit;

  assign wr_hit    = rf.wr_en_in    && (rf.rd_addr_in       != '0);
  assign issue_hit = rf.issue_en_in && (rf.issue_rd_addr_in != '0);

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_next = busy_reg;
    if (wr_hit)
      busy_next[rf.rd_addr_in] = 1'b0;
    if (issue_hit)
      busy_next[rf.issue_rd_addr_in] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      busy_reg <= '0;
      for (int i = 0; i < NREG; i++)
        regs_reg[i] <= '0;
    end else begin
      busy_reg <= busy_next;
      if (wr_hit)
        regs_reg[rf.rd_addr_in] <= rf.rd_in;
    end
  end

  logic [ADDR_WIDTH-1:0] rs_addr [2];
  logic [DATA_WIDTH-1:0] rs_data [2];
  logic                  rs_busy [2];

  assign rs_addr[0] = rf.rs_1_addr_in;
  assign rs_addr[1] = rf.rs_2_addr_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic addr_zero;
      assign addr_zero = (rs_addr[gi] == '0);
`ifdef MSRV32_RF_WB_BYPASS_EN
      logic fwd_hit;
      logic reissue;
      // Forwarding is suppressed under reset so outputs stay zero while it is held.
      assign fwd_hit = wr_hit && !ms_riscv32_mp_rst_in && (rf.rd_addr_in == rs_addr[gi]);
      assign reissue = issue_hit && (rf.issue_rd_addr_in == rs_addr[gi]);
      assign rs_data[gi] = addr_zero ? '0   : (fwd_hit ? rf.rd_in : regs_reg[rs_addr[gi]]);
      assign rs_busy[gi] = addr_zero ? 1'b0 : (fwd_hit ? reissue  : busy_reg[rs_addr[gi]]);
`else
      assign rs_data[gi] = addr_zero ? '0   : regs_reg[rs_addr[gi]];
      assign rs_busy[gi] = addr_zero ? 1'b0 : busy_reg[rs_addr[gi]];
`endif
    end
  endgenerate

  assign rf.rs_1_out      = rs_data[0];
  assign rf.rs_2_out      = rs_data[1];
  assign rf.rs_1_busy_out = rs_busy[0];
  assign rf.rs_2_busy_out = rs_busy[1];
  assign rf.stall_out     = rs_busy[0] | rs_busy[1];
endmodule
